// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared types and constants for the Ethernet TX arbiter.
package eth_tx_pkg;

    // Arbiter FSM: wait for a request, start the MAC, wait for completion, gap.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GO   = 2'd1,
        ST_SEND = 2'd2,
        ST_IFG  = 2'd3
    } tx_state_t;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

    // Idle cycles between frames, and default watchdog limit.
    localparam int IFG_DEFAULT  = 12;
    localparam int WDOG_DEFAULT = 4096;

endpackage

// File: rtl/eth_tx_rr_arb.sv
// eth_tx_rr_arb: 2-way round-robin arbiter. The pointer names the source
// that currently has priority; the source granted last loses priority.
module eth_tx_rr_arb (
    input  logic       gmii_tx_clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic ptr;

    // One-hot grant: the priority source wins if requesting, else the other.
    always_comb begin
        grant = 2'b00;
        if (ptr == 1'b0) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

    // Hand priority to the source that was not granted; source 0 first after reset.
    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst)                   ptr <= 1'b0;
        else if (update && |grant) ptr <= grant[0];
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: schedules the single eth_send MAC between the ARP (0) and
// UDP/IP (1) frame builders. Optional watchdog: define ETH_TX_ARB_WDOG_EN.
//
// Handshakes: a source raises req[i] and holds it until done[i] pulses; the
// grant is taken from req in IDLE only, so a req drop after the grant is
// ignored. Byte reads are forwarded combinationally: mac_fifo_rdreq is passed
// to the granted source as src_rdreq and its byte is returned on
// mac_fifo_rddata in the same cycle; with no grant the MAC reads 0x00.
module eth_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int IFG_CYCLES  = IFG_DEFAULT,
    parameter int WDOG_CYCLES = WDOG_DEFAULT
) (
    input  logic        gmii_tx_clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [31:0] req_len,
    input  logic [95:0] req_dst_mac,
    input  logic [31:0] req_type,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        err,
    output logic        busy,
    input  logic [15:0] src_rddata,
    output logic [1:0]  src_rdreq,
    output logic        mac_tx_go,
    output logic [15:0] mac_data_length,
    output logic [47:0] mac_des_mac,
    output logic [15:0] mac_type_length,
    input  logic        mac_fifo_rdreq,
    output logic [7:0]  mac_fifo_rddata,
    input  logic        mac_send_done,
    output logic [1:0]  state_dbg
);

    localparam logic [15:0] IFG_LOAD = 16'(IFG_CYCLES - 1);

    tx_state_t   state, state_d;
    logic [1:0]  gnt_d, done_d;
    logic        err_d;
    logic [15:0] ifg_cnt, ifg_d;
    logic [1:0]  arb_grant;
    logic        arb_update;
    logic        wd_expire;

    eth_tx_rr_arb u_rr_arb (
        .gmii_tx_clk (gmii_tx_clk),
        .rst         (rst),
        .req         (req),
        .update      (arb_update),
        .grant       (arb_grant)
    );

`ifdef ETH_TX_ARB_WDOG_EN
    logic [31:0] wd_cnt;

    // Cycles elapsed since tx_go; expiry aborts a frame the MAC never finished.
    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst)                    wd_cnt <= '0;
        else if (state == ST_GO)    wd_cnt <= 32'd1;
        else if (state == ST_SEND)  wd_cnt <= wd_cnt + 32'd1;
    end

    // A send_done on the expiry cycle wins: it is a normal completion.
    assign wd_expire = (state == ST_SEND) && (wd_cnt == 32'(WDOG_CYCLES - 1)) && !mac_send_done;
`else
    // No watchdog: SEND waits for send_done indefinitely (a negative limit never occurs).
    assign wd_expire = (WDOG_CYCLES < 0);
`endif

    // State and registered control outputs.
    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt     <= 2'b00;
            done    <= 2'b00;
            err     <= 1'b0;
            ifg_cnt <= 16'd0;
        end else begin
            state   <= state_d;
            gnt     <= gnt_d;
            done    <= done_d;
            err     <= err_d;
            ifg_cnt <= ifg_d;
        end
    end

    // Next-state logic: grant in IDLE, start MAC in GO, complete in SEND, gap in IFG.
    always_comb begin
        state_d    = state;
        gnt_d      = gnt;
        done_d     = 2'b00;
        err_d      = 1'b0;
        ifg_d      = ifg_cnt;
        arb_update = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    arb_update = 1'b1;
                    gnt_d      = arb_grant;
                    state_d    = ST_GO;
                end
            end
            ST_GO: begin
                if (mac_data_length == 16'd0) begin
                    // Nothing to send: complete at once, no gap.
                    done_d  = gnt;
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (mac_send_done || wd_expire) begin
                    done_d = gnt;
                    gnt_d  = 2'b00;
                    err_d  = wd_expire;
                    if (IFG_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        ifg_d   = IFG_LOAD;
                        state_d = ST_IFG;
                    end
                end
            end
            ST_IFG: begin
                if (ifg_cnt == 16'd0) state_d = ST_IDLE;
                else                  ifg_d   = ifg_cnt - 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the winner's frame parameters at grant; held until the next grant.
    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            mac_data_length <= 16'd0;
            mac_des_mac     <= 48'd0;
            mac_type_length <= 16'd0;
        end else if (arb_update) begin
            mac_data_length <= arb_grant[1] ? req_len[31:16]     : req_len[15:0];
            mac_des_mac     <= arb_grant[1] ? req_dst_mac[95:48] : req_dst_mac[47:0];
            mac_type_length <= arb_grant[1] ? req_type[31:16]    : req_type[15:0];
        end
    end

    // Byte-read steering to the granted source.
    always_comb begin
        src_rdreq = {2{mac_fifo_rdreq}} & gnt;
        if (gnt[1])      mac_fifo_rddata = src_rddata[15:8];
        else if (gnt[0]) mac_fifo_rddata = src_rddata[7:0];
        else             mac_fifo_rddata = 8'h00;
    end

    assign mac_tx_go = (state == ST_GO) && (mac_data_length != 16'd0);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed bench for eth_tx_arbiter (table of frames plus
// hand-written contention, reset and watchdog sequences).
`timescale 1ns/1ps
module tb_eth_tx_arbiter;
    import eth_tx_pkg::*;

    localparam int IFG = 12;
    localparam int WD  = 64;
    localparam logic [47:0] MAC0 = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MAC1 = 48'h0011_2233_4455;

    logic        gmii_tx_clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] req_len;
    logic [95:0] req_dst_mac;
    logic [31:0] req_type;
    logic [1:0]  gnt, done;
    logic        err, busy;
    logic [15:0] src_rddata;
    logic [1:0]  src_rdreq;
    logic        mac_tx_go;
    logic [15:0] mac_data_length;
    logic [47:0] mac_des_mac;
    logic [15:0] mac_type_length;
    logic        mac_fifo_rdreq;
    logic [7:0]  mac_fifo_rddata;
    logic        mac_send_done;
    logic [1:0]  state_dbg;

    eth_tx_arbiter #(.IFG_CYCLES(IFG), .WDOG_CYCLES(WD)) dut (
        .gmii_tx_clk     (gmii_tx_clk),
        .rst             (rst),
        .req             (req),
        .req_len         (req_len),
        .req_dst_mac     (req_dst_mac),
        .req_type        (req_type),
        .gnt             (gnt),
        .done            (done),
        .err             (err),
        .busy            (busy),
        .src_rddata      (src_rddata),
        .src_rdreq       (src_rdreq),
        .mac_tx_go       (mac_tx_go),
        .mac_data_length (mac_data_length),
        .mac_des_mac     (mac_des_mac),
        .mac_type_length (mac_type_length),
        .mac_fifo_rdreq  (mac_fifo_rdreq),
        .mac_fifo_rddata (mac_fifo_rddata),
        .mac_send_done   (mac_send_done),
        .state_dbg       (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #4 gmii_tx_clk = ~gmii_tx_clk;

    int cyc = 0;
    always @(posedge gmii_tx_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each grant pushes the done pattern it must produce.
    logic [1:0] exp_q[$];

    always @(negedge gmii_tx_clk) begin
        if (!rst && done != 2'b00) begin
            if (exp_q.size() == 0) chk("done_unexpected", {62'd0, done}, 64'd0);
            else                   chk("done_sb", {62'd0, done}, {62'd0, exp_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge gmii_tx_clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && t < 100) begin
            step();
            t++;
        end
        chk(name, {63'd0, busy}, 64'd0);
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [15:0] len0;
        logic [15:0] len1;
        logic [1:0]  exp_gnt;
        logic        exp_go;
        logic [15:0] exp_len;
        logic [47:0] exp_mac;
        logic [15:0] exp_type;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        int go_cnt;
        int ifg_n;
        req_len    = {v.len1, v.len0};
        src_rddata = {v.d1, v.d0};
        req        = v.req;
        step();                                   // cycle N+1
        chk("gnt", {62'd0, gnt}, {62'd0, v.exp_gnt});
        chk("tx_go", {63'd0, mac_tx_go}, {63'd0, v.exp_go});
        chk("len", {48'd0, mac_data_length}, {48'd0, v.exp_len});
        chk("mac", {16'd0, mac_des_mac}, {16'd0, v.exp_mac});
        chk("type", {48'd0, mac_type_length}, {48'd0, v.exp_type});
        chk("busy", {63'd0, busy}, 64'd1);
        exp_q.push_back(v.exp_gnt);
        mac_fifo_rdreq = 1'b1;
        #1;
        chk("rddata", {56'd0, mac_fifo_rddata}, {56'd0, v.exp_rd});
        chk("src_rdreq", {62'd0, src_rdreq}, {62'd0, v.exp_gnt});
        mac_fifo_rdreq = 1'b0;
        if (v.exp_go) begin
            go_cnt = 0;
            repeat (3 + idx) begin
                step();
                if (mac_tx_go) go_cnt++;
            end
            chk("go_once", go_cnt, 0);
            chk("len_stable", {48'd0, mac_data_length}, {48'd0, v.exp_len});
            mac_send_done = 1'b1;
            step();                               // done cycle
            mac_send_done = 1'b0;
            chk("done", {62'd0, done}, {62'd0, v.exp_gnt});
            chk("gnt_clr", {62'd0, gnt}, 64'd0);
            chk("err_low", {63'd0, err}, 64'd0);
            chk("state_ifg", {62'd0, state_dbg}, {62'd0, ST_IFG});
            req   = 2'b00;
            ifg_n = 0;
            while (busy && ifg_n < 50) begin
                ifg_n++;
                if (ifg_n == 2) chk("done_one_cycle", {62'd0, done}, 64'd0);
                mac_send_done = (ifg_n == 3);     // stray send_done must be ignored
                step();
            end
            mac_send_done = 1'b0;
            chk("ifg_len", ifg_n, IFG);
            chk("len_hold", {48'd0, mac_data_length}, {48'd0, v.exp_len});
        end else begin
            step();                               // cycle N+2
            chk("zl_done", {62'd0, done}, {62'd0, v.exp_gnt});
            chk("zl_busy", {63'd0, busy}, 64'd0);
            chk("zl_gnt", {62'd0, gnt}, 64'd0);
            chk("zl_go", {63'd0, mac_tx_go}, 64'd0);
            req = 2'b00;
            step();
            chk("zl_no_ifg", {63'd0, busy}, 64'd0);
        end
    endtask

    // ---------------- test ----------------
    logic [1:0] cont_exp[3] = '{2'b01, 2'b10, 2'b01};

    initial begin
        int t;
        int last_done;
        int go_cyc;
        int ifg_n;

        rst            = 1'b1;
        req            = 2'b00;
        req_len        = 32'd0;
        req_dst_mac    = {MAC1, MAC0};
        req_type       = {ETHERTYPE_IPV4, ETHERTYPE_ARP};
        src_rddata     = 16'h0000;
        mac_fifo_rdreq = 1'b0;
        mac_send_done  = 1'b0;

        vecs[0] = '{2'b01, 16'd46, 16'd100,  2'b01, 1'b1, 16'd46,   MAC0, ETHERTYPE_ARP,  8'h45, 8'h48, 8'h45};
        vecs[1] = '{2'b10, 16'd46, 16'd100,  2'b10, 1'b1, 16'd100,  MAC1, ETHERTYPE_IPV4, 8'h45, 8'h48, 8'h48};
        vecs[2] = '{2'b11, 16'd60, 16'd200,  2'b01, 1'b1, 16'd60,   MAC0, ETHERTYPE_ARP,  8'h11, 8'h22, 8'h11};
        vecs[3] = '{2'b11, 16'd60, 16'd200,  2'b10, 1'b1, 16'd200,  MAC1, ETHERTYPE_IPV4, 8'h11, 8'h22, 8'h22};
        vecs[4] = '{2'b10, 16'd60, 16'd0,    2'b10, 1'b0, 16'd0,    MAC1, ETHERTYPE_IPV4, 8'h33, 8'h44, 8'h44};
        vecs[5] = '{2'b11, 16'd0,  16'd28,   2'b01, 1'b0, 16'd0,    MAC0, ETHERTYPE_ARP,  8'h5A, 8'hA5, 8'h5A};
        vecs[6] = '{2'b01, 16'd28, 16'd28,   2'b01, 1'b1, 16'd28,   MAC0, ETHERTYPE_ARP,  8'h66, 8'h77, 8'h66};
        vecs[7] = '{2'b11, 16'd28, 16'd1500, 2'b10, 1'b1, 16'd1500, MAC1, ETHERTYPE_IPV4, 8'h66, 8'h77, 8'h77};

        // Reset state.
        repeat (3) step();
        chk("rst_gnt", {62'd0, gnt}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_len", {48'd0, mac_data_length}, 64'd0);
        chk("rst_mac", {16'd0, mac_des_mac}, 64'd0);
        rst = 1'b0;
        step();
        chk("idle_state", {62'd0, state_dbg}, {62'd0, ST_IDLE});
        chk("idle_done", {62'd0, done}, 64'd0);
        mac_fifo_rdreq = 1'b1;
        src_rddata     = 16'h4845;
        #1;
        chk("idle_rddata", {56'd0, mac_fifo_rddata}, 64'd0);
        chk("idle_src_rdreq", {62'd0, src_rdreq}, 64'd0);
        mac_fifo_rdreq = 1'b0;

        // Table of single frames.
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Contention: both held, grants alternate with a full gap between.
        req_len   = {16'd64, 16'd64};
        req       = 2'b11;
        last_done = 0;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (gnt == 2'b00 && t < 40) begin
                step();
                t++;
            end
            chk("cont_gnt", {62'd0, gnt}, {62'd0, cont_exp[k]});
            if (k > 0) chk("cont_gap", cyc - last_done - 1, IFG);
            exp_q.push_back(cont_exp[k]);
            repeat (2) step();
            mac_send_done = 1'b1;
            step();
            mac_send_done = 1'b0;
            last_done = cyc;
            chk("cont_done", {62'd0, done}, {62'd0, cont_exp[k]});
            if (k == 2) req = 2'b00;
        end
        wait_idle("cont_idle");

        // Reset mid-SEND: everything clears at once, pointer returns to source 0.
        req_len = {16'd80, 16'd80};
        req     = 2'b01;
        step();
        chk("rs_gnt", {62'd0, gnt}, 64'd1);
        exp_q.push_back(2'b01);
        step();
        mac_fifo_rdreq = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("rs_gnt_clr", {62'd0, gnt}, 64'd0);
        chk("rs_busy", {63'd0, busy}, 64'd0);
        chk("rs_go", {63'd0, mac_tx_go}, 64'd0);
        chk("rs_len", {48'd0, mac_data_length}, 64'd0);
        chk("rs_mac", {16'd0, mac_des_mac}, 64'd0);
        chk("rs_type", {48'd0, mac_type_length}, 64'd0);
        chk("rs_src_rdreq", {62'd0, src_rdreq}, 64'd0);
        chk("rs_rddata", {56'd0, mac_fifo_rddata}, 64'd0);
        exp_q.delete();
        mac_fifo_rdreq = 1'b0;
        req            = 2'b00;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        chk("rs_no_done", {62'd0, done}, 64'd0);
        req = 2'b11;
        step();
        chk("rs_rr_restart", {62'd0, gnt}, 64'd1);
        exp_q.push_back(2'b01);
        repeat (2) step();
        mac_send_done = 1'b1;
        step();
        mac_send_done = 1'b0;
        req = 2'b00;
        wait_idle("rs_idle");

`ifdef ETH_TX_ARB_WDOG_EN
        // Watchdog: no send_done, abort WD cycles after tx_go.
        req_len = {16'd64, 16'd64};
        req     = 2'b01;
        step();
        chk("wd_go", {63'd0, mac_tx_go}, 64'd1);
        go_cyc = cyc;
        exp_q.push_back(2'b01);
        t = 0;
        while (!err && t < 200) begin
            step();
            t++;
        end
        chk("wd_err_delay", cyc - go_cyc, WD);
        chk("wd_done", {62'd0, done}, 64'd1);
        chk("wd_gnt_clr", {62'd0, gnt}, 64'd0);
        req   = 2'b00;
        ifg_n = 0;
        while (busy && ifg_n < 50) begin
            ifg_n++;
            step();
        end
        chk("wd_ifg", ifg_n, IFG);
`else
        go_cyc = 0;
        ifg_n  = 0;
`endif

        step();
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Schedules access to the single `eth_send` MAC transmitter between two frame sources: an ARP requester (index 0) and a UDP/IP requester (index 1). It arbitrates round-robin and latches the winner's frame parameters. It then issues `tx_go`, steers the MAC's byte-read handshake to the granted source, waits for `send_done`, and enforces an inter-frame gap. It sits between the protocol-layer packet builders and `eth_send`, all in the `gmii_tx_clk` domain.

## Interface
- `IFG_CYCLES`, default 12: idle cycles inserted after each `send_done` before the next grant.
- `WDOG_CYCLES`, default 4096: watchdog limit, in cycles, from `tx_go` to `send_done`. Used only when the watchdog is compiled in.

Ports:
- `gmii_tx_clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  2  per-source frame request; the source holds it until its `done` pulse.
- `req_len`  in  32  {len1, len0}; the IP/ARP payload length passed to MAC `data_length`.
- `req_dst_mac`  in  96  {mac1, mac0}; destination MAC of each source.
- `req_type`  in  32  {type1, type0}; EtherType of each source (0x0806 ARP, 0x0800 IPv4).
- `gnt`  out  2  one-hot grant; held from latch until completion.
- `done`  out  2  one-cycle completion pulse to the granted source.
- `err`  out  1  one-cycle watchdog-abort pulse.
- `busy`  out  1  high in any state other than IDLE.
- `src_rddata`  in  16  {d1, d0}; current payload byte of each source.
- `src_rdreq`  out  2  read request forwarded to the granted source only.
- `mac_tx_go`  out  1  one-cycle start pulse to `eth_send`.
- `mac_data_length`  out  16  latched length.
- `mac_des_mac`  out  48  latched destination MAC.
- `mac_type_length`  out  16  latched EtherType.
- `mac_fifo_rdreq`  in  1  byte request from `eth_send`.
- `mac_fifo_rddata`  out  8  byte returned to `eth_send`.
- `mac_send_done`  in  1  frame-complete pulse from `eth_send`.

## Operation
- FSM states: IDLE, GO, SEND, IFG.
- IDLE:
  - If any `req` bit is high, the round-robin picks the winner.
  - The winner's length, MAC and type are latched, `gnt` is set, and the FSM moves to GO.
  - Round-robin rule: the source granted last has lowest priority. After reset, source 0 has priority.
- GO: `mac_tx_go` is high for exactly this cycle. The FSM moves to SEND.
- SEND: wait for `mac_send_done`. On it:
  - pulse `done[g]`;
  - clear `gnt`;
  - load the IFG counter with `IFG_CYCLES-1` and move to IFG.
- IFG: count down to 0, then return to IDLE. With `IFG_CYCLES`=0, the FSM goes from SEND straight to IDLE.
- Zero-length request (`req_len` slice == 0):
  - granted, but no `tx_go` is issued;
  - `done` pulses in the cycle after the grant, the FSM returns to IDLE, and no IFG is inserted.
- Byte-read datapath:
  - `src_rdreq` = `mac_fifo_rdreq` & `gnt`, combinational.
  - `mac_fifo_rddata` = the granted source's `src_rddata` byte, or 0x00 when no grant is active.
- `req` deasserting during GO/SEND is ignored: the frame completes and `done` still pulses.
- A `req` still high after its `done` is re-arbitrated after IFG under the normal round-robin rule.
- A `mac_send_done` arriving outside SEND is ignored.
- Latched parameters are held stable from the grant until the next grant.

## Timing
- Reset values:
  - all outputs 0;
  - `mac_data_length`, `mac_des_mac`, `mac_type_length` = 0;
  - FSM in IDLE; round-robin pointer favours source 0.
- Cycle numbering:
  - `req` sampled high in cycle N gives `gnt` and latched parameters registered at N+1.
  - `mac_tx_go` is high in cycle N+1.
- `done`/`err` are high in the cycle after `mac_send_done`/watchdog expiry is sampled.
- The next grant comes no earlier than `IFG_CYCLES`+1 cycles after `done`.
- Simultaneous requests in IDLE: exactly one grant, per round-robin.
- `rst` asserted mid-frame: the FSM and outputs clear immediately (asynchronously), and no `done` is issued.

## Configuration
- Macro: `ETH_TX_ARB_WDOG_EN`.
- Defined:
  - a counter starts at GO;
  - if `WDOG_CYCLES` elapse in SEND without `mac_send_done`, `err` pulses, `done[g]` pulses, `gnt` clears, and the FSM enters IFG;
  - `mac_send_done` coinciding with expiry counts as a normal completion, and `err` stays 0.
- Undefined: no counter is built, `err` is tied 0, and SEND waits indefinitely.

## Structure
- Package `eth_tx_pkg` holds:
  - the FSM state enum;
  - `ETHERTYPE_IPV4` = 16'h0800 and `ETHERTYPE_ARP` = 16'h0806;
  - the default IFG constant.
- Sub-module `eth_tx_rr_arb`: 2-way round-robin arbiter (request, update pulse → one-hot grant, pointer register).

## Test plan
- Single request: `req`=01, len0=46, mac0=FF..FF, type0=0806. Expect `gnt`=01 and one `tx_go` at N+1, outputs stable; after `mac_send_done`, `done`=01 for one cycle, then 12 idle cycles.
- Contention: `req`=11 held. Grants alternate 01, 10, 01, with exactly 12 cycles between each `done` and the next `gnt`.
- Read steering: granted 1, d1=0x48, d0=0x45, `mac_fifo_rdreq`=1. Expect `mac_fifo_rddata`=0x48 and `src_rdreq`=10; idle read gives 0x00.
- Zero length: `req`=10, len1=0. Expect no `tx_go`, `done`=10 at N+2, and no IFG.
- Reset mid-SEND: assert `rst`. All outputs go to 0 immediately and no `done` is issued; after release, the first grant goes to source 0.
- With `ETH_TX_ARB_WDOG_EN`, `WDOG_CYCLES`=64, and no `send_done`: `err` and `done` pulse 64 cycles after `tx_go`, followed by IFG.
